// File: rtl/clk_domain_sequencer_pkg.sv
// Shared definitions for the post-PLL clock-domain sequencer: FSM encoding
// and the sizing helpers used to dimension its counter.
package clk_domain_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Never returns less than 1 so a degenerate range still yields a legal vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_domain_sequencer_if.sv
// Lock input, rate increments and per-channel reset/enable outputs of the
// sequencer, plus its FSM state for observation.
interface clk_domain_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 16
);
    import clk_domain_sequencer_pkg::*;

    logic                    pll_lock;
    logic [NUM_CH*ACC_W-1:0] inc;
    logic [NUM_CH-1:0]       rst_out;
    logic [NUM_CH-1:0]       ce_out;
    // ready is a level, not a handshake: high only while every channel is out
    // of reset and lock is still held; it drops on the edge after lock loss.
    logic                    ready;
    logic                    lock_lost;
    seq_state_e              state;

    modport master (
        output pll_lock, inc,
        input  rst_out, ce_out, ready, lock_lost, state
    );

    modport slave (
        input  pll_lock, inc,
        output rst_out, ce_out, ready, lock_lost, state
    );

endinterface

// File: rtl/clk_domain_sequencer_phase_accum_ce.sv
// One fractional-rate clock-enable channel: a phase accumulator whose carry
// out becomes a registered single-cycle strobe.
module phase_accum_ce #(
    parameter int ACC_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clock) begin
        if (clear) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            {ce, acc} <= {1'b0, acc} + {1'b0, inc};
        end
    end

endmodule

// File: rtl/clk_domain_sequencer.sv
// Filters PLL lock, releases per-channel resets in staggered order and drives
// one phase-accumulator clock enable per channel.
module clk_domain_sequencer
    import clk_domain_sequencer_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_FILTER = 16,
    parameter int RST_HOLD    = 64,
    parameter int STAGGER     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    clk_domain_sequencer_if.slave   bus
);

    localparam int LAST_K = (NUM_CH - 1) * STAGGER;
    localparam int CNT_W  = clog2(max3(LOCK_FILTER, RST_HOLD, LAST_K + 1));

    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] rst_q;
    logic [NUM_CH-1:0] ce;
    logic              ready_q;
    logic              lost_q;
    logic              lock_drop;

    // Once lock has been accepted, any low sample aborts the sequence.
    assign lock_drop = (state != WAIT_LOCK) && !bus.pll_lock;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
        end else if (lock_drop) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!bus.pll_lock) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(RST_HOLD - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (cnt == CNT_W'(i * STAGGER)) rst_q[i] <= 1'b0;
                    end
                    if (cnt == CNT_W'(LAST_K)) begin
                        state   <= RUN;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Accumulators clear on the same edge the resets reassert, not one later.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        phase_accum_ce #(.ACC_W(ACC_W)) u_accum (
            .clock (clock),
            .clear (reset | rst_q[g] | lock_drop),
            .inc   (bus.inc[g*ACC_W +: ACC_W]),
            .ce    (ce[g])
        );
    end

    assign bus.rst_out   = rst_q;
    assign bus.ce_out    = ce;
    assign bus.ready     = ready_q;
    assign bus.lock_lost = lost_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_clk_domain_sequencer.sv
// Bench for clk_domain_sequencer: directed bring-up/lock-loss/reset scenarios
// followed by randomized lock and rate stimulus against a timeline model.
module tb_clk_domain_sequencer;
    import clk_domain_sequencer_pkg::*;

    localparam int NUM_CH      = 2;
    localparam int ACC_W       = 8;
    localparam int LOCK_FILTER = 4;
    localparam int RST_HOLD    = 8;
    localparam int STAGGER     = 2;
    localparam int REL0        = RST_HOLD + 1;
    localparam int RUN_E       = RST_HOLD + 1 + (NUM_CH - 1) * STAGGER;

    logic clock = 1'b0;
    logic reset = 1'b1;

    clk_domain_sequencer_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

    clk_domain_sequencer #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_FILTER (LOCK_FILTER),
        .RST_HOLD    (RST_HOLD),
        .STAGGER     (STAGGER)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Timeline model: lock acceptance time plus elapsed edges decide everything.
    bit                m_valid = 1'b0;
    bit                m_accepted;
    bit                m_lost;
    int                m_run;
    int                m_e;
    int                m_acc [NUM_CH];
    logic [NUM_CH-1:0] m_ce;
    logic [NUM_CH-1:0] m_rst;
    bit                m_ready;

    always @(posedge clock) begin
        logic [NUM_CH-1:0] rst_before;
        bit drop;
        int sum;
        rst_before = m_rst;
        if (reset) begin
            m_accepted = 1'b0;
            m_lost     = 1'b0;
            m_run      = 0;
            m_e        = 0;
            for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
            m_ce       = '0;
            m_valid    = 1'b1;
        end else begin
            drop = m_accepted && !bus.pll_lock;
            if (drop) begin
                m_accepted = 1'b0;
                m_lost     = 1'b1;
                m_run      = 0;
            end else if (m_accepted) begin
                m_e++;
            end else if (bus.pll_lock) begin
                m_run++;
                if (m_run == LOCK_FILTER) begin
                    m_accepted = 1'b1;
                    m_e        = 0;
                    m_run      = 0;
                end
            end else begin
                m_run = 0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (drop || rst_before[i]) begin
                    m_acc[i] = 0;
                    m_ce[i]  = 1'b0;
                end else begin
                    sum      = m_acc[i] + int'(bus.inc[i*ACC_W +: ACC_W]);
                    m_ce[i]  = (sum >= (1 << ACC_W));
                    m_acc[i] = sum % (1 << ACC_W);
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) m_rst[i] = !(m_accepted && m_e >= REL0 + i * STAGGER);
        m_ready = m_accepted && (m_e >= RUN_E);
    end

    function automatic int model_state();
        if (!m_accepted) return 0;
        if (m_e < RST_HOLD) return 1;
        if (m_e < RUN_E) return 2;
        return 3;
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            check("rst_out", 32'(bus.rst_out), 32'(m_rst));
            check("ce_out", 32'(bus.ce_out), 32'(m_ce));
            check("ready", 32'(bus.ready), 32'(m_ready));
            check("lock_lost", 32'(bus.lock_lost), 32'(m_lost));
            check("state", 32'(bus.state), 32'(model_state()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        bus.inc      = '0;
        reset        = 1'b1;
        tick(3);
        check("reset_rst_out", 32'(bus.rst_out), 32'h3);
        check("reset_lock_lost", 32'(bus.lock_lost), 32'h0);

        // Steady lock from t0; rates 0x40 / 0x80.
        reset   = 1'b0;
        bus.pll_lock = 1'b1;
        bus.inc = {8'h80, 8'h40};
        tick(12);
        check("t1_rst_t11", 32'(bus.rst_out), 32'h3);
        tick(1);
        check("t1_rst_t12", 32'(bus.rst_out), 32'h2);
        check("t1_ready_t12", 32'(bus.ready), 32'h0);
        tick(1);
        check("t1_rst_t13", 32'(bus.rst_out), 32'h2);
        tick(1);
        check("t1_rst_t14", 32'(bus.rst_out), 32'h0);
        check("t1_ready_t14", 32'(bus.ready), 32'h1);
        check("t1_lost_t14", 32'(bus.lock_lost), 32'h0);
        tick(1);
        check("t3_ce_t15", 32'(bus.ce_out), 32'h0);
        tick(1);
        check("t3_ce_t16", 32'(bus.ce_out), 32'h3);
        tick(1);
        check("t3_ce_t17", 32'(bus.ce_out), 32'h0);
        tick(1);
        check("t3_ce_t18", 32'(bus.ce_out), 32'h2);
        bus.inc[7:0] = 8'h00;
        for (int n = 0; n < 10; n++) begin
            tick(1);
            check("t3_ce0_zero", 32'(bus.ce_out[0]), 32'h0);
        end

        // One-cycle lock drop in RUN, then re-lock.
        bus.pll_lock = 1'b0;
        tick(1);
        check("t4_rst", 32'(bus.rst_out), 32'h3);
        check("t4_ce", 32'(bus.ce_out), 32'h0);
        check("t4_ready", 32'(bus.ready), 32'h0);
        check("t4_lost", 32'(bus.lock_lost), 32'h1);
        bus.pll_lock = 1'b1;
        tick(12);
        check("t4_rst_t11", 32'(bus.rst_out), 32'h3);
        tick(1);
        check("t4_rst_t12", 32'(bus.rst_out), 32'h2);
        tick(2);
        check("t4_rst_t14", 32'(bus.rst_out), 32'h0);
        check("t4_lost_kept", 32'(bus.lock_lost), 32'h1);

        // Drop at release counter k=1, after a fresh lock-loss restart.
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        tick(13);
        check("t5_rst_k0", 32'(bus.rst_out), 32'h2);
        bus.pll_lock = 1'b0;
        tick(1);
        check("t5_rst", 32'(bus.rst_out), 32'h3);
        check("t5_state", 32'(bus.state), 32'(WAIT_LOCK));

        // Lock pattern 1,1,1,0 then steady.
        for (int n = 0; n < 3; n++) begin
            bus.pll_lock = 1'b1;
            tick(1);
        end
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        tick(12);
        check("t2_rst_t11", 32'(bus.rst_out), 32'h3);
        tick(1);
        check("t2_rst_t12", 32'(bus.rst_out), 32'h2);
        tick(3);
        check("t2_ready", 32'(bus.ready), 32'h1);

        // Reset in RUN with lock held.
        reset = 1'b1;
        tick(1);
        check("t6_rst", 32'(bus.rst_out), 32'h3);
        check("t6_ready", 32'(bus.ready), 32'h0);
        check("t6_lost", 32'(bus.lock_lost), 32'h0);
        check("t6_state", 32'(bus.state), 32'(WAIT_LOCK));
        reset = 1'b0;
        tick(12);
        check("t6_rst_t11", 32'(bus.rst_out), 32'h3);
        tick(1);
        check("t6_rst_t12", 32'(bus.rst_out), 32'h2);

        // Randomized lock glitches, rates and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 599) == 0);
            bus.pll_lock = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 15) == 0) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    case ($urandom_range(0, 3))
                        0:       bus.inc[ch*ACC_W +: ACC_W] = '0;
                        1:       bus.inc[ch*ACC_W +: ACC_W] = '1;
                        default: bus.inc[ch*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, (1 << ACC_W) - 1));
                    endcase
                end
            end
            tick(1);
        end

        reset = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
